// File: rtl/alu_rs_if.sv
// Dispatch, CDB snoop and issue signals of the ALU reservation station.
// The decoder/CDB/ALU side uses the master modport; the station uses the slave.
interface alu_rs_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int OP_W   = 6
);
  localparam int PKT_W = (TAG_W - 1) + 2 * (TAG_W + DATA_W) + OP_W;

  // Dispatch is a valid/stall pair: a packet is accepted on a rising edge only
  // when aluEnable=1 and rsFull=0; with rsFull=1 the packet is dropped.
  logic              aluEnable;
  logic [PKT_W-1:0]  aluData;
  logic              rsFull;
  logic              cdbValid;
  logic [TAG_W-2:0]  cdbTag;
  logic [DATA_W-1:0] cdbData;
  logic              exValid;
  logic [OP_W-1:0]   exOp;
  logic [DATA_W-1:0] exData1;
  logic [DATA_W-1:0] exData2;
  logic [TAG_W-2:0]  exRob;

  modport master (
    output aluEnable, aluData, cdbValid, cdbTag, cdbData,
    input  rsFull, exValid, exOp, exData1, exData2, exRob
  );

  modport slave (
    input  aluEnable, aluData, cdbValid, cdbTag, cdbData,
    output rsFull, exValid, exOp, exData1, exData2, exRob
  );
endinterface

// File: rtl/alu_rs.sv
// ALU reservation station: buffers decoded ALU ops, captures operands from the
// CDB and issues the lowest-index operand-complete entry each cycle.
module alu_rs #(
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 4,
  parameter int OP_W    = 6,
  parameter int ENTRIES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  alu_rs_if.slave rs
);
  localparam int ROB_W = TAG_W - 1;
  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam logic [TAG_W-1:0] TAG_FREE = {1'b1, {ROB_W{1'b0}}};

  logic [ENTRIES-1:0] busy_q, busy_d;
  logic [OP_W-1:0]    op_q    [ENTRIES];
  logic [OP_W-1:0]    op_d    [ENTRIES];
  logic [ROB_W-1:0]   rob_q   [ENTRIES];
  logic [ROB_W-1:0]   rob_d   [ENTRIES];
  logic [TAG_W-1:0]   tag1_q  [ENTRIES];
  logic [TAG_W-1:0]   tag1_d  [ENTRIES];
  logic [TAG_W-1:0]   tag2_q  [ENTRIES];
  logic [TAG_W-1:0]   tag2_d  [ENTRIES];
  logic [DATA_W-1:0]  data1_q [ENTRIES];
  logic [DATA_W-1:0]  data1_d [ENTRIES];
  logic [DATA_W-1:0]  data2_q [ENTRIES];
  logic [DATA_W-1:0]  data2_d [ENTRIES];

  logic              ex_valid_q, ex_valid_d;
  logic [OP_W-1:0]   ex_op_q, ex_op_d;
  logic [DATA_W-1:0] ex_data1_q, ex_data1_d;
  logic [DATA_W-1:0] ex_data2_q, ex_data2_d;
  logic [ROB_W-1:0]  ex_rob_q, ex_rob_d;

  logic [OP_W-1:0]   in_op;
  logic [DATA_W-1:0] in_data1, in_data2;
  logic [TAG_W-1:0]  in_tag1, in_tag2;
  logic [ROB_W-1:0]  in_rob;

  logic [ENTRIES-1:0] ready;
  logic               issue_hit, alloc_hit;
  logic [IDX_W-1:0]   issue_idx, alloc_idx;

  assign in_op    = rs.aluData[OP_W-1:0];
  assign in_data1 = rs.aluData[OP_W +: DATA_W];
  assign in_tag1  = rs.aluData[OP_W+DATA_W +: TAG_W];
  assign in_data2 = rs.aluData[OP_W+DATA_W+TAG_W +: DATA_W];
  assign in_tag2  = rs.aluData[OP_W+2*DATA_W+TAG_W +: TAG_W];
  assign in_rob   = rs.aluData[OP_W+2*(DATA_W+TAG_W) +: ROB_W];

  // Full and selection look only at registered state, so an entry freed by
  // this cycle's issue is reusable from the next cycle on.
  assign rs.rsFull = &busy_q;

  always_comb begin
    issue_hit = 1'b0;
    issue_idx = '0;
    alloc_hit = 1'b0;
    alloc_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      ready[i] = busy_q[i] & tag1_q[i][TAG_W-1] & tag2_q[i][TAG_W-1];
      if (ready[i]) begin
        issue_hit = 1'b1;
        issue_idx = IDX_W'(i);
      end
      if (!busy_q[i]) begin
        alloc_hit = 1'b1;
        alloc_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    busy_d     = busy_q;
    op_d       = op_q;
    rob_d      = rob_q;
    tag1_d     = tag1_q;
    tag2_d     = tag2_q;
    data1_d    = data1_q;
    data2_d    = data2_q;
    ex_valid_d = 1'b0;
    ex_op_d    = ex_op_q;
    ex_data1_d = ex_data1_q;
    ex_data2_d = ex_data2_q;
    ex_rob_d   = ex_rob_q;

    for (int i = 0; i < ENTRIES; i++) begin
      if (busy_q[i] && rs.cdbValid) begin
        if (!tag1_q[i][TAG_W-1] && tag1_q[i][ROB_W-1:0] == rs.cdbTag) begin
          tag1_d[i]  = TAG_FREE;
          data1_d[i] = rs.cdbData;
        end
        if (!tag2_q[i][TAG_W-1] && tag2_q[i][ROB_W-1:0] == rs.cdbTag) begin
          tag2_d[i]  = TAG_FREE;
          data2_d[i] = rs.cdbData;
        end
      end
    end

    if (clear) begin
      busy_d = '0;
    end else begin
      if (issue_hit) begin
        busy_d[issue_idx] = 1'b0;
        ex_valid_d        = 1'b1;
        ex_op_d           = op_q[issue_idx];
        ex_data1_d        = data1_q[issue_idx];
        ex_data2_d        = data2_q[issue_idx];
        ex_rob_d          = rob_q[issue_idx];
      end
      if (rs.aluEnable && alloc_hit) begin
        busy_d[alloc_idx]  = 1'b1;
        op_d[alloc_idx]    = in_op;
        rob_d[alloc_idx]   = in_rob;
        tag1_d[alloc_idx]  = in_tag1;
        data1_d[alloc_idx] = in_data1;
        tag2_d[alloc_idx]  = in_tag2;
        data2_d[alloc_idx] = in_data2;
        // Operand broadcast in the dispatch cycle would otherwise be missed.
        if (rs.cdbValid && !in_tag1[TAG_W-1] && in_tag1[ROB_W-1:0] == rs.cdbTag) begin
          tag1_d[alloc_idx]  = TAG_FREE;
          data1_d[alloc_idx] = rs.cdbData;
        end
        if (rs.cdbValid && !in_tag2[TAG_W-1] && in_tag2[ROB_W-1:0] == rs.cdbTag) begin
          tag2_d[alloc_idx]  = TAG_FREE;
          data2_d[alloc_idx] = rs.cdbData;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q     <= '0;
      ex_valid_q <= 1'b0;
      ex_op_q    <= '0;
      ex_data1_q <= '0;
      ex_data2_q <= '0;
      ex_rob_q   <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        op_q[i]    <= '0;
        rob_q[i]   <= '0;
        tag1_q[i]  <= TAG_FREE;
        tag2_q[i]  <= TAG_FREE;
        data1_q[i] <= '0;
        data2_q[i] <= '0;
      end
    end else begin
      busy_q     <= busy_d;
      ex_valid_q <= ex_valid_d;
      ex_op_q    <= ex_op_d;
      ex_data1_q <= ex_data1_d;
      ex_data2_q <= ex_data2_d;
      ex_rob_q   <= ex_rob_d;
      for (int i = 0; i < ENTRIES; i++) begin
        op_q[i]    <= op_d[i];
        rob_q[i]   <= rob_d[i];
        tag1_q[i]  <= tag1_d[i];
        tag2_q[i]  <= tag2_d[i];
        data1_q[i] <= data1_d[i];
        data2_q[i] <= data2_d[i];
      end
    end
  end

  assign rs.exValid = ex_valid_q;
  assign rs.exOp    = ex_op_q;
  assign rs.exData1 = ex_data1_q;
  assign rs.exData2 = ex_data2_q;
  assign rs.exRob   = ex_rob_q;
endmodule

// File: doc/alu_rs.md
# alu_rs

ALU reservation station: the receiving end of the decoder's ALU dispatch packet. It buffers up to `ENTRIES` decoded ALU operations, captures missing operands by snooping the common data bus (CDB), and issues at most one operand-complete operation per cycle to the ALU. It sits between the decoder (upstream, combinational dispatch) and the ALU (downstream, always accepts).

## Interface
- `DATA_W`, 32, operand/result width
- `TAG_W`, 4, tag width; MSB=1 means "free/no dependency" (`TAG_FREE` = 1 followed by zeros), MSB=0 means ROB index in low `TAG_W-1` bits
- `OP_W`, 6, internal opcode width
- `ENTRIES`, 4, station depth (power of 2, ≥2)
- Dispatch packet layout, MSB→LSB: `{rob[TAG_W-2:0], tag2, data2, tag1, data1, op}`; width `PKT_W = (TAG_W-1) + 2*(TAG_W+DATA_W) + OP_W`

Ports:
- `clk` in 1 — single clock, rising edge
- `rst` in 1 — asynchronous, active-high reset
- `clear` in 1 — synchronous flush (ROB misprediction recovery)
- `aluEnable` in 1 — dispatch valid from decoder
- `aluData` in PKT_W — dispatch packet
- `rsFull` out 1 — no free entry; decoder must stall
- `cdbValid` in 1 — CDB broadcast valid
- `cdbTag` in TAG_W-1 — ROB index being broadcast
- `cdbData` in DATA_W — broadcast value
- `exValid` out 1 — issued op valid (registered)
- `exOp` out OP_W — opcode
- `exData1` out DATA_W — operand 1
- `exData2` out DATA_W — operand 2
- `exRob` out TAG_W-1 — destination ROB index

## Operation
- Per entry: `busy`, `op`, `rob`, `tag1/data1`, `tag2/data2`. Operand ready iff tag MSB = 1.
- Allocation: when `aluEnable && !rsFull && !clear`, packet written to lowest-index non-busy entry at next edge. `aluEnable` while `rsFull` is dropped (no write, no error).
- Dispatch bypass: if an incoming operand tag (MSB=0) equals `cdbTag` while `cdbValid` in the same cycle, entry stores `cdbData` and `TAG_FREE` for that operand.
- Wake-up: every busy entry with operand tag MSB=0 and low bits == `cdbTag` while `cdbValid` stores `cdbData`, tag ← `TAG_FREE`. Both operands of one entry may wake on the same broadcast.
- Issue select: lowest-index busy entry with both operands ready (not age-ordered). At edge: entry `busy` cleared, fields copied to `ex*`, `exValid`=1. No ready entry → `exValid`=0 next cycle; `ex*` data holds last value.
- Issue considers state at start of cycle only; an entry woken or allocated this cycle is not issued this cycle.
- `rsFull` = all entries busy, combinational from registered `busy` only (not reduced by same-cycle issue).
- `clear`: at edge all `busy` ← 0, `exValid` ← 0; concurrent allocation and issue suppressed. `clear` dominates.
- Reset: all `busy`=0, all tags=`TAG_FREE`, `exValid`=0, `exOp`=0, `exData1`=0, `exData2`=0, `exRob`=0; `rsFull`=0.

## Timing
- Dispatch with both operands ready at edge E0 → `exValid`=1 with that op after E1 (one cycle in station minimum).
- Operand woken at edge Ec → entry eligible in cycle after Ec; issued at Ec+1 earliest.
- Throughput: one allocation and one issue per cycle concurrently.
- Full boundary: with `ENTRIES` busy and one issuing in cycle C, `rsFull` stays 1 in C; deasserts in C+1.
- Allocation into a just-freed entry occurs no earlier than cycle after its issue edge.
- Reset mid-operation: asynchronous, outputs take reset values immediately, no partial issue.

## Test plan
- Reset/basic: assert `rst` mid-stream → `exValid`=0, `rsFull`=0 immediately; dispatch ADD, data1=5, data2=7, both tags `TAG_FREE`, rob=3 → one cycle later `exValid`=1, `exData1`=5, `exData2`=7, `exRob`=3, then `exValid`=0.
- Wake-up: dispatch with tag1=2 (MSB 0), tag2 free; hold 3 cycles → no issue; `cdbValid`, `cdbTag`=2, `cdbData`=0x1234 → issue next cycle with `exData1`=0x1234.
- Bypass: dispatch tag1=5 in same cycle as CDB tag 5 data 0xAA → entry captures 0xAA, issues after one cycle with `exData1`=0xAA.
- Full/stall: fill 4 entries all waiting on tag 1 → `rsFull`=1; 5th `aluEnable` dropped; broadcast tag 1 → four consecutive issues, entries 0..3 in order, `rsFull` drops in cycle after first issue.
- Clear: 3 busy entries plus concurrent dispatch and `clear` → all entries empty, `exValid`=0, later CDB broadcast produces no issue.
- Dual wake and priority: entry 2 ready, entry 0 waiting on tags 4 and 4; broadcast tag 4 → entry 2 issues first, entry 0 next cycle with both operands = `cdbData`.
